seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter: accepts a parallel bit pattern over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It can repeat the frame a programmed number of times, with programmable idle gaps between repeats. It is the stimulus/transmit side of the serial pattern-detection path; its default pattern (5'b10101) drives the 10101 sequence detectors directly.

## Interface
- PAT_W, 5, pattern length in bits (minimum 2)
- REP_W, 4, width of repeat-count field
- GAP_W, 4, width of inter-frame gap field
- clk  input  1  clock; all logic is rising-edge
- reset  input  1  asynchronous, active-high; clock clk
- pat_valid  input  1  request carrying pat_data/rep_count/gap
- pat_ready  output  1  block can accept a request; high only in IDLE
- pat_data  input  PAT_W  pattern, bit PAT_W-1 transmitted first
- rep_count  input  REP_W  number of frames to send; 0 is treated as 1
- gap  input  GAP_W  idle cycles between consecutive frames
- abort  input  1  synchronous cancel of the transfer in progress
- dout  output  1  serial data bit
- dout_valid  output  1  dout carries a pattern bit this cycle
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last bit of the last frame

## Operation
- States: IDLE, SHIFT, GAP, DONE. State is encoded in a registered state vector.
- IDLE: pat_ready=1. On pat_valid&&pat_ready at a clock edge, the block latches pat_data into the shift register, latches max(rep_count,1) into the repeat counter, latches gap, sets bit index to PAT_W-1, and moves to SHIFT.
- SHIFT: dout = shift register MSB and dout_valid=1. Each edge shifts left by one and decrements the bit index.
- After bit 0 of a frame, the repeat counter decrements. The next state is chosen as follows:
  - Last frame: DONE.
  - More frames and gap>0: GAP.
  - More frames and gap=0: reload the latched pattern and stay in SHIFT. Frames are then back-to-back with no bubble.
- GAP: dout=0, dout_valid=0 for exactly gap cycles. The block then reloads the pattern and enters SHIFT.
- DONE: done=1 for one cycle, then IDLE. pat_ready=0 in DONE.
- Latched copies of the pattern and gap are used for the whole transfer. The inputs may change after acceptance.
- pat_valid outside IDLE is ignored. No request is queued.
- abort: from SHIFT, GAP or DONE, the next edge goes to IDLE with done not pulsed. abort in IDLE has no effect and does not block acceptance.
- Outside SHIFT: dout=0 and dout_valid=0.
- Counters: the bit index is clog2(PAT_W) bits wide and the gap counter is GAP_W bits. The repeat counter is REP_W bits and never wraps because 0 maps to 1.

## Timing
- Reset values: state IDLE, dout=0, dout_valid=0, busy=0, done=0, pat_ready=1. The shift register and all counters are cleared.
- Reset mid-transfer returns to IDLE immediately (asynchronous). No done pulse is produced and no partial bits follow.
- Acceptance at edge E: the first bit appears on dout with dout_valid=1 in the cycle following E.
- Cycle count from the first bit to the last bit: R*PAT_W + (R-1)*gap, where R = max(rep_count,1).
- done is high in the cycle after the last bit. pat_ready returns in the cycle after done, so the minimum request-to-request spacing is R*PAT_W + (R-1)*gap + 2 cycles.
- pat_ready, busy and dout_valid are decoded from registered state only, with no combinational input-to-output paths. dout comes from the shift register.
- abort and a last-bit edge in the same cycle: abort wins, giving IDLE with no done.

## Test plan
- Reset, then pat_data=10101, rep_count=1, gap=0 accepted at cycle 0:
  - dout = 1,0,1,0,1 with dout_valid=1 in cycles 1-5.
  - done=1 in cycle 6; pat_ready=1 again in cycle 7.
- pat_data=10101, rep_count=3, gap=0:
  - 15 consecutive valid bits 101011010110101.
  - done in cycle 16; busy high cycles 1-16.
- pat_data=10101, rep_count=2, gap=2:
  - Bits 10101, then 2 cycles dout_valid=0/dout=0, then 10101.
  - done in cycle 13.
- rep_count=0, pat_data=11001: exactly one frame 11001 is sent. A pat_valid pulse during SHIFT is ignored: no second frame and pat_ready stays 0.
- abort during the 3rd bit of frame 1 of a rep_count=2 transfer:
  - IDLE on the next edge; dout_valid=0; no done; pat_ready=1.
  - Reset asserted mid-frame gives the same result asynchronously.
- Loopback: dout gated by dout_valid feeds the 10101 Moore detector; pattern 10101, rep_count=4, gap=2. The detector reports exactly 4 detections, and no detection for pattern 10111.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle for seq_pattern_tx.
// The master drives requests and abort; the slave (the transmitter) drives status and the serial stream.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 5,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
);
  logic             pat_valid;
  logic             pat_ready;
  logic [PAT_W-1:0] pat_data;
  logic [REP_W-1:0] rep_count;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output pat_valid, pat_data, rep_count, gap, abort,
    input  pat_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  pat_valid, pat_data, rep_count, gap, abort,
    output pat_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// a programmed number of times with programmable idle gaps between frames.
module seq_pattern_tx #(
  parameter int PAT_W = 5,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  seq_pattern_tx_if.slave    bus
);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.pat_valid) begin
          state_d = S_SHIFT;
          shift_d = bus.pat_data;
          pat_d   = bus.pat_data;
          rep_d   = (bus.rep_count == '0) ? REP_W'(1) : bus.rep_count;
          gap_d   = bus.gap;
          idx_d   = LAST_IDX;
        end
      end
      S_SHIFT: begin
        shift_d = {shift_q[PAT_W-2:0], 1'b0};
        if (idx_q == '0) begin
          // rep_q never drops below 1, so <= 1 marks the final frame
          if (rep_q <= REP_W'(1)) begin
            state_d = S_DONE;
          end else begin
            rep_d = rep_q - REP_W'(1);
            if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else begin
              shift_d = pat_q;
              idx_d   = LAST_IDX;
            end
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = S_SHIFT;
          shift_d = pat_q;
          idx_d   = LAST_IDX;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including the last-bit transition into DONE
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.pat_ready  = (state_q == S_IDLE);
    bus.busy       = (state_q != S_IDLE);
    bus.dout_valid = (state_q == S_SHIFT);
    bus.dout       = (state_q == S_SHIFT) && shift_q[PAT_W-1];
    bus.done       = (state_q == S_DONE);
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and randomized checks of seq_pattern_tx against a frame-list model,
// plus a 10101 sliding-window detector on the gated serial stream.
module tb_seq_pattern_tx;
  localparam int PAT_W = 5;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   dets;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status vector: {pat_ready, busy, done, dout_valid, dout}
  function automatic logic [4:0] obs_vec();
    return {bus.pat_ready, bus.busy, bus.done, bus.dout_valid, bus.dout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one request and checks every cycle until pat_ready returns.
  // Expected trace is built from the frame list: R frames of MSB-first bits,
  // gap idle cycles between frames, one done cycle, then ready.
  task automatic run_request(input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] rep,
                             input logic [GAP_W-1:0] gp, input int poke_at,
                             input bit abort_at_accept, input string tag, output int n_det);
    logic [4:0] exp_q[$];
    logic [4:0] win;
    int r;
    r = (rep == 0) ? 1 : int'(rep);
    for (int f = 0; f < r; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({3'b010, 1'b1, pat[b]});
      if (f < r - 1) for (int g = 0; g < int'(gp); g++) exp_q.push_back(5'b01000);
    end
    exp_q.push_back(5'b01100);
    exp_q.push_back(5'b10000);

    @(negedge clk);
    check({tag, "_ready_before"}, 32'(bus.pat_ready), 32'd1);
    bus.pat_valid = 1'b1;
    bus.pat_data  = pat;
    bus.rep_count = rep;
    bus.gap       = gp;
    bus.abort     = abort_at_accept;
    @(posedge clk);
    #1;
    bus.pat_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.pat_data  = PAT_W'($urandom);
    bus.rep_count = REP_W'($urandom);
    bus.gap       = GAP_W'($urandom);

    win   = '0;
    n_det = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), 32'(obs_vec()), 32'(exp_q[i]));
      win = {win[3:0], bus.dout & bus.dout_valid};
      if (win == 5'b10101) n_det++;
      bus.pat_valid = (i == poke_at);
    end
    bus.pat_valid = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.pat_valid = 1'b0;
    bus.pat_data  = '0;
    bus.rep_count = '0;
    bus.gap       = '0;
    bus.abort     = 1'b0;

    #1;
    check("reset_async", 32'(obs_vec()), 32'b10000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(obs_vec()), 32'b10000);

    run_request(5'b10101, 4'd1, 4'd0, -1, 1'b0, "single", dets);
    run_request(5'b10101, 4'd3, 4'd0, -1, 1'b0, "b2b3", dets);
    run_request(5'b10101, 4'd2, 4'd2, -1, 1'b0, "gap2", dets);
    run_request(5'b11001, 4'd0, 4'd0, 1, 1'b0, "rep0_poke", dets);
    run_request(5'b01110, 4'd2, 4'd1, -1, 1'b1, "abort_idle", dets);

    // Abort during the 3rd bit of frame 1 of a two-frame transfer
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 5'b10101;
    bus.rep_count = 4'd2;
    bus.gap       = 4'd0;
    @(posedge clk);
    #1;
    bus.pat_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_bit3", 32'(obs_vec()), 32'b01011);
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_idle_next", 32'(obs_vec()), 32'b10000);
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet[%0d]", i), 32'(obs_vec()), 32'b10000);
    end

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 5'b11001;
    bus.rep_count = 4'd1;
    @(posedge clk);
    #1;
    bus.pat_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_midframe_pre", 32'(obs_vec()), 32'b01011);
    #2;
    reset = 1'b1;
    #1;
    check("rst_midframe_async", 32'(obs_vec()), 32'b10000);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_quiet[%0d]", i), 32'(obs_vec()), 32'b10000);
    end

    // Loopback through a 10101 window detector
    run_request(5'b10101, 4'd4, 4'd2, -1, 1'b0, "loop_10101", dets);
    check("loop_10101_dets", 32'(dets), 32'd4);
    run_request(5'b10111, 4'd4, 4'd2, -1, 1'b0, "loop_10111", dets);
    check("loop_10111_dets", 32'(dets), 32'd0);

    // Randomized requests
    for (int k = 0; k < 10; k++) begin
      run_request(PAT_W'($urandom), REP_W'($urandom_range(0, 4)),
                  GAP_W'($urandom_range(0, 4)), -1, 1'b0,
                  $sformatf("rand%0d", k), dets);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
